// File: rtl/seven_segment_scan_controller.sv
// Scans a multi-digit nibble value onto one shared seven-segment decoder with
// per-slot dead time, leading-zero blanking and frame-atomic value updates.
`timescale 1ns/1ps

module seven_segment_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lz_blank_en,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    blank,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_valid;

    logic [NUM_DIGITS-1:0]   upper_zero;
    logic                    suppress;
    logic                    frame_end;
    logic                    drive_on;
    logic [3:0]              digit_nxt;
    logic [NUM_DIGITS-1:0]   anode_nxt;
    logic                    blank_nxt;
    logic                    frame_done_nxt;

    assign frame_end = en && (cnt == CNT_LAST) && (idx == IDX_LAST);

    // upper_zero[i] is set when digits i..NUM_DIGITS-1 of the shown value are all zero.
    always_comb begin : zero_scan
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc           = acc && (display[4*i +: 4] == 4'd0);
            upper_zero[i] = acc;
        end
    end

    assign suppress = lz_blank_en && (idx != '0) && upper_zero[idx];

    // State register; IDLE with en=1 is the cnt=0 blank cycle of slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_BLANK: state_nxt = (cnt == CNT_BLANK_LAST) ? S_DRIVE : S_BLANK;
                S_DRIVE:         state_nxt = (cnt == CNT_LAST) ? S_BLANK : S_DRIVE;
                default:         state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        drive_on       = en && (state == S_DRIVE) && !suppress;
        digit_nxt      = display[4*int'(idx) +: 4];
        anode_nxt      = drive_on ? ~(NUM_DIGITS'(1) << idx) : '1;
        blank_nxt      = !drive_on;
        frame_done_nxt = frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // New values land in display only at a frame end or while idle, never mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display       <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else if (load) begin
            if (frame_end || !en) begin
                display       <= value;
                pending_valid <= 1'b0;
            end else begin
                pending       <= value;
                pending_valid <= 1'b1;
            end
        end else if (pending_valid && (frame_end || !en)) begin
            display       <= pending;
            pending_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit      <= 4'd0;
            anode_n    <= '1;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            digit      <= digit_nxt;
            anode_n    <= anode_nxt;
            blank      <= blank_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: doc/seven_segment_scan_controller.md
Name: seven_segment_scan_controller

Overview:
- Time-multiplexes a multi-digit hex/BCD value onto one shared seven_segment_decoder and a common-anode display in the muon lifetime readout.
- Drives the decoder's 4-bit digit input and an active-low anode select, one digit per refresh slot.
- Inserts dead time between digits to prevent ghosting and blanks leading zeros on request.
- Double-buffers the displayed value so updates apply only at frame boundaries, so no frame ever mixes old and new digits.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= 4).
- BLANK_CYCLES, 500, dead-time cycles at the start of each slot (1 <= BLANK_CYCLES < REFRESH_DIV).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; 0 forces idle.
- value  input  4*NUM_DIGITS  nibble i = digit i; nibble 0 is the rightmost digit.
- load  input  1  single-cycle strobe that captures value.
- lz_blank_en  input  1  enables leading-zero blanking.
- digit  output  4  nibble to the seven_segment_decoder.
- anode_n  output  NUM_DIGITS  active-low digit enables.
- blank  output  1  high when no anode is driven.
- frame_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: anode_n all ones, digit=0, blank=1, frame_done=0.
  - Internal: slot counter cnt=0, index idx=0, display register=0, pending register=0, pending_valid=0.
  - Reset mid-frame aborts the scan immediately and discards any pending load.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Counters:
  - cnt runs 0..REFRESH_DIV-1. At wrap, idx increments 0..NUM_DIGITS-1, then wraps to 0.
  - Widths are $clog2 of each range.
- FSM, per slot:
  - BLANK: cycles cnt=0..BLANK_CYCLES-1. anode_n all ones, blank=1.
  - DRIVE: cycles cnt=BLANK_CYCLES..REFRESH_DIV-1. anode_n[idx]=0 and all other bits 1, blank=0, unless the slot is suppressed.
  - BLANK -> DRIVE when cnt reaches BLANK_CYCLES.
  - DRIVE -> BLANK at slot wrap.
- Outputs reflect the state one cycle after the counter update (one-cycle registered latency, constant).
- digit = display[idx*4 +: 4] for the whole slot, including BLANK, so the decoder settles before the anode turns on.
- Leading-zero suppression:
  - Applies when lz_blank_en=1 and every nibble from idx up to NUM_DIGITS-1 is 0, with idx>0.
  - A suppressed slot keeps all anodes off and blank=1.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
- Load / double buffering:
  - load=1 copies value into the pending register and sets pending_valid.
  - A second load before the frame boundary overwrites pending (last write wins).
- Frame boundary (last cycle of slot NUM_DIGITS-1):
  - frame_done=1 for exactly one cycle.
  - If pending_valid, display <= pending and pending_valid clears.
  - If load coincides with this cycle, the incoming value goes directly into display and pending_valid ends cleared.
- en=0:
  - Next cycle: cnt=0, idx=0, anode_n all ones, blank=1, frame_done=0.
  - Load capture still works. A pending value is applied immediately while en=0, so the next enabled frame shows the latest value.
- en 0->1: scanning restarts at slot 0, BLANK, cnt=0.
- No state is lost on the idx wrap.

Test Plan:
Every scenario uses NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset/idle: hold rst_n=0, then release with en=0 for 20 cycles -> anode_n=4'b1111, blank=1, digit=0, frame_done never pulses. Assert rst_n=0 mid-DRIVE -> anode_n goes to 1111 without waiting for a clock edge.
- Scan order/timing: en=1, load value=16'h1234 -> first full frame shows digit 4,3,2,1 in slots 0..3.
  - In each slot: 2 cycles anode_n=1111, then 6 cycles anode_n=1110 / 1101 / 1011 / 0111 respectively.
  - frame_done pulses every 32 cycles.
- Frame-atomic update: while scanning 16'h1234, load 16'hABCD at slot 1 and then 16'h5678 at slot 2 -> the current frame completes with 1234, and the next frame shows 8,7,6,5 (ABCD is never displayed).
- Load at boundary: load 16'h0F0F on the frame_done cycle -> the very next slot 0 shows digit=F, and pending_valid=0 afterwards.
- Leading-zero blanking: lz_blank_en=1, value=16'h0070.
  - Slots 0 and 1 driven with digit 0 and 7.
  - Slots 2 and 3 keep anode_n=1111 and blank=1.
  - value=16'h0000: only slot 0 is driven.
  - lz_blank_en=0: all four slots are driven.
- Enable toggle: drop en during slot 2 -> the next cycle is idle with all anodes off. Re-raise en -> scanning restarts at slot 0 BLANK with cnt=0.
